mem_access_sequencer: RTL

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

---
 rtl/mem_access_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// Multi-cycle control sequencer for a fetch/decode/execute datapath with a
// single shared memory port; exposes its FSM state and a retired-instruction count.
module mem_access_sequencer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           opcode,
    input  logic [3:0]           ext_op,
    input  logic                 cond_true,
    input  logic                 mem_ready,
    output logic                 addr_sel,
    output logic                 ir_load,
    output logic                 pc_en,
    output logic                 pc_src,
    output logic                 mem_we,
    output logic                 rf_we,
    output logic                 wb_sel,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam logic [2:0] FETCH   = 3'd0;
    localparam logic [2:0] DECODE  = 3'd1;
    localparam logic [2:0] EXEC    = 3'd2;
    localparam logic [2:0] LOAD    = 3'd3;
    localparam logic [2:0] LOAD_WB = 3'd4;
    localparam logic [2:0] STORE   = 3'd5;
    localparam logic [2:0] JUMP    = 3'd6;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0] cur;
    logic [2:0] nxt;
    logic       retire;

    // Memory handshake: a memory phase (FETCH, LOAD, STORE) holds its address
    // and strobes stable and completes only in the cycle mem_ready is 1; each
    // cycle with mem_ready=0 is one wait state.
    always_comb begin
        nxt    = FETCH;
        retire = 1'b0;
        case (cur)
            FETCH:   nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (opcode == 4'h4 && ext_op == 4'h0)
                    nxt = LOAD;
                else if (opcode == 4'h4 && ext_op == 4'h4)
                    nxt = STORE;
                else if (opcode == 4'h4 && ext_op == 4'hC)
                    nxt = JUMP;
                else
                    nxt = EXEC;
            end
            EXEC: begin
                nxt    = FETCH;
                retire = 1'b1;
            end
            LOAD:    nxt = mem_ready ? LOAD_WB : LOAD;
            LOAD_WB: begin
                nxt    = FETCH;
                retire = 1'b1;
            end
            STORE: begin
                nxt    = mem_ready ? FETCH : STORE;
                retire = mem_ready;
            end
            JUMP: begin
                nxt    = FETCH;
                retire = 1'b1;
            end
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= FETCH;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (retire)
                retired <= retired + CNT_ONE;
        end
    end

    // Gated by reset so the mem_ready-dependent strobes also drop immediately.
    always_comb begin
        addr_sel = 1'b0;
        ir_load  = 1'b0;
        pc_en    = 1'b0;
        pc_src   = 1'b0;
        mem_we   = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        if (!reset) begin
            case (cur)
                FETCH:   ir_load = mem_ready;
                EXEC: begin
                    rf_we = 1'b1;
                    pc_en = 1'b1;
                end
                LOAD:    addr_sel = 1'b1;
                LOAD_WB: begin
                    addr_sel = 1'b1;
                    rf_we    = 1'b1;
                    wb_sel   = 1'b1;
                    pc_en    = 1'b1;
                end
                STORE: begin
                    addr_sel = 1'b1;
                    mem_we   = 1'b1;
                    pc_en    = mem_ready;
                end
                JUMP: begin
                    pc_en  = 1'b1;
                    pc_src = cond_true;
                end
                default: ;
            endcase
        end
    end

    assign state = cur;

endmodule
